// File: rtl/uart_rx_byte_fifo.sv
// Receive-side byte FIFO: captures a byte on each rising edge of rx_done and serves it
// on a first-word fall-through valid/ready stream. Optional macro: RX_FIFO_ALMOST_FULL_EN.
module uart_rx_byte_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int AF_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              flush,
  input  logic              clear_ovf,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
`ifdef RX_FIFO_ALMOST_FULL_EN
  output logic              almost_full,
`endif
  output logic              overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              done_q;
  logic              push_req;
  logic              pop;
  logic              push_acc;
  logic              drop;
  logic [AW:0]       count_next;

  // Stream handshake: a byte transfers in any cycle where m_valid and m_ready are both
  // high; m_valid never depends on m_ready, and m_data holds the head until it transfers.
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign m_valid  = ~empty;
  assign m_data   = empty ? '0 : mem[rd_ptr];

  assign push_req = rx_done & ~done_q;
  assign pop      = m_valid & m_ready;
  // A pop on the same cycle frees the slot, so a full FIFO can still take the byte.
  assign push_acc = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    count_next = count;
    case ({push_acc, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_acc && !flush) begin
      mem[wr_ptr] <= rx_data;
    end
  end

`ifdef RX_FIFO_ALMOST_FULL_EN
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_THRESH);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // done_q starts high so a done already asserted at reset release is not a new frame.
      done_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
`ifdef RX_FIFO_ALMOST_FULL_EN
      almost_full <= 1'b0;
`endif
    end else begin
      done_q <= rx_done;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
`ifdef RX_FIFO_ALMOST_FULL_EN
        almost_full <= 1'b0;
`endif
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + AW'(1);
        if (pop)      rd_ptr <= rd_ptr + AW'(1);
        count <= count_next;
        if (drop) begin
          overflow <= 1'b1;
        end else if (clear_ovf) begin
          overflow <= 1'b0;
        end
`ifdef RX_FIFO_ALMOST_FULL_EN
        almost_full <= (count_next >= AF_CNT);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Directed bench for uart_rx_byte_fifo: a vector table for single-cycle behaviour plus
// hand-written sequences for fill/overflow, full push+pop, flush and asynchronous reset.
module tb_uart_rx_byte_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       flush;
  logic       clear_ovf;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
`ifdef RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_rx_byte_fifo dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .flush(flush), .clear_ovf(clear_ovf), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .count(count), .full(full), .empty(empty),
`ifdef RX_FIFO_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       ready;
    logic       fl;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: apply inputs away from the edge, then sample 1 ns after the active edge
  task automatic step(input logic d, input logic [7:0] b, input logic r,
                      input logic f, input logic c);
    @(negedge clk);
    rx_done = d; rx_data = b; m_ready = r; flush = f; clear_ovf = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk(name, {31'd0, m_valid}, 32'd1);
    chk(name, {24'd0, m_data}, {24'd0, e});
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; flush = 1'b0; clear_ovf = 1'b0; m_ready = 1'b0;

    //         done data  rdy fl clr  valid data   cnt  full ovf
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_data", {24'd0, m_data}, 32'd0);
    chk("reset_count", {27'd0, count}, 32'd0);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].done, vecs[i].data, vecs[i].ready, vecs[i].fl, vecs[i].clr);
      chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_data", i), {24'd0, m_data}, {24'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d_count", i), {27'd0, count}, {27'd0, vecs[i].exp_count});
      chk($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end

    // fill to full, drop one byte, drain in order
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    chk("fill_count", {27'd0, count}, 32'd16);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_ovf", {31'd0, overflow}, 32'd0);
    push_byte(8'hFF);
    chk("drop_count", {27'd0, count}, 32'd16);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    while (exp_q.size() > 0) pop_check("drain1");
    chk("drain1_empty", {31'd0, empty}, 32'd1);
    chk("drain1_data", {24'd0, m_data}, 32'd0);
    chk("drain1_ovf_sticky", {31'd0, overflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clear_ovf", {31'd0, overflow}, 32'd0);

    // refill, set-wins over clear, then push+pop while full
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h20 + 8'(i));
      exp_q.push_back(8'h20 + 8'(i));
    end
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("set_wins_ovf", {31'd0, overflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clear_ovf2", {31'd0, overflow}, 32'd0);
    chk("pp_head", {24'd0, m_data}, {24'd0, exp_q[0]});
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("pp_count", {27'd0, count}, 32'd16);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    chk("pp_next_head", {24'd0, m_data}, 32'h21);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) pop_check("drain2");
    chk("drain2_empty", {31'd0, empty}, 32'd1);

    // flush together with a done rising edge at count=5
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    chk("pre_flush_count", {27'd0, count}, 32'd5);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("flush_count", {27'd0, count}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    chk("flush_ovf", {31'd0, overflow}, 32'd0);
    chk("flush_data", {24'd0, m_data}, 32'd0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    chk("post_flush_count", {27'd0, count}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef RX_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 11; i++) push_byte(8'(i));
    chk("af_11", {31'd0, almost_full}, 32'd0);
    push_byte(8'h0B);
    chk("af_12", {31'd0, almost_full}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("af_pop", {31'd0, almost_full}, 32'd0);
    push_byte(8'h0C);
    chk("af_refill", {31'd0, almost_full}, 32'd1);
`endif

    // asynchronous reset mid-stream, with rx_done held high across release
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
    @(negedge clk);
    rx_done = 1'b1; rx_data = 8'hDD;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", {27'd0, count}, 32'd0);
    chk("arst_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_data", {24'd0, m_data}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_full", {31'd0, full}, 32'd0);
`ifdef RX_FIFO_ALMOST_FULL_EN
    chk("arst_af", {31'd0, almost_full}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
    chk("held_done_count", {27'd0, count}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", {27'd0, count}, 32'd1);
    chk("post_rst_data", {24'd0, m_data}, 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
